// File: rtl/pc_pkg.sv
// pc_pkg: shared op encoding for the program-counter sequencer
package pc_pkg;
    localparam int PC_OP_W = 3;
    typedef enum logic [PC_OP_W-1:0] {
        NEXT   = 3'd0,
        JUMP   = 3'd1,
        BRANCH = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4
    } pc_op_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular LIFO return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_ovf_evt,
    output logic         o_unf_evt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_inc;
    logic [PW-1:0] w_dec;
    assign w_inc     = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
    assign w_dec     = (r_ptr == '0) ? PW'(DEPTH - 1) : r_ptr - PW'(1);
    assign o_top     = r_mem[w_dec];
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_ovf_evt = i_push && o_full;
    assign o_unf_evt = i_pop && o_empty;
    // write pointer and occupancy; the pointer keeps wrapping when full so the oldest slot is reused
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_ptr <= w_inc;
            if (!o_full) r_cnt <= r_cnt + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_ptr <= w_dec;
            r_cnt <= r_cnt - CW'(1);
        end
    end
    // entry storage
    always_ff @(posedge clk) begin
        if (rst_n && i_push) r_mem[r_ptr] <= i_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with jump/branch and optional return-address stack (PC_SEQ_RAS_EN)
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int STEP      = 4,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic [PC_OP_W-1:0] op,
    input  logic [PC_W-1:0]    target,
    input  logic [PC_W-1:0]    offset,
    input  logic               err_clr,
    output logic [PC_W-1:0]    pc,
    output logic               ras_empty,
    output logic               ras_full,
    output logic               ras_ovf,
    output logic               ras_unf
);
    pc_op_e          w_op;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_pc_nxt;
    assign w_op  = pc_op_e'(op);
    assign w_seq = r_pc + PC_W'(STEP);
    assign pc    = r_pc;
`ifdef PC_SEQ_RAS_EN
    logic [PC_W-1:0] w_top;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_ovf_evt;
    logic            w_unf_evt;
    logic            r_ovf;
    logic            r_unf;
    assign w_push = !stall && (w_op == CALL);
    assign w_pop  = !stall && (w_op == RET);
    pc_ras #(
        .DEPTH(RAS_DEPTH),
        .W    (PC_W)
    ) u_ras (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (w_seq),
        .o_top    (w_top),
        .o_empty  (w_empty),
        .o_full   (ras_full),
        .o_ovf_evt(w_ovf_evt),
        .o_unf_evt(w_unf_evt)
    );
    // sticky error flags: a new event wins over err_clr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt ? 1'b1 : (err_clr ? 1'b0 : r_ovf);
            r_unf <= w_unf_evt ? 1'b1 : (err_clr ? 1'b0 : r_unf);
        end
    end
    assign ras_empty = w_empty;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif
    // next-PC select; CALL redirects like JUMP, RET on an empty stack falls through to sequential
    always_comb begin
        w_pc_nxt = (w_op == JUMP || w_op == CALL) ? target :
                   (w_op == BRANCH) ? r_pc + offset : w_seq;
`ifdef PC_SEQ_RAS_EN
        if (w_op == RET && !w_empty) w_pc_nxt = w_top;
`endif
    end
    // PC register
    always_ff @(posedge clk) begin
        if (!rst_n) r_pc <= PC_W'(RESET_VEC);
        else if (!stall) r_pc <= w_pc_nxt;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven and sequence checks of pc_sequencer with a scoreboard queue
module tb_pc_sequencer;
    import pc_pkg::*;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    localparam bit NR = !RAS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        err_clr = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] target = '0;
    logic [15:0] offset = '0;
    logic [15:0] pc;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;

    typedef struct {
        string       name;
        logic        st;
        logic [2:0]  op;
        logic [15:0] tgt;
        logic [15:0] off;
        logic [15:0] pc;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        e, f, o, u;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W(16), .STEP(4), .RESET_VEC(0), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .op(op),
        .target(target), .offset(offset), .err_clr(err_clr),
        .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input string n, input logic rn, input logic st, input logic [2:0] o,
                        input logic [15:0] t, input logic [15:0] off, input logic clr,
                        input logic [15:0] epc, input logic ee, input logic ef,
                        input logic eo, input logic eu);
        exp_t x;
        rst_n = rn; stall = st; op = o; target = t; offset = off; err_clr = clr;
        sb.push_back('{n, epc, ee, ef, eo, eu});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.name, ".pc"}, pc, x.pc);
        chk({x.name, ".empty"}, 16'(ras_empty), 16'(x.e));
        chk({x.name, ".full"}, 16'(ras_full), 16'(x.f));
        chk({x.name, ".ovf"}, 16'(ras_ovf), 16'(x.o));
        chk({x.name, ".unf"}, 16'(ras_unf), 16'(x.u));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"next1",   1'b0, NEXT,   16'h0000, 16'h0000, 16'h0004};
        vecs[1]  = '{"next2",   1'b0, NEXT,   16'h0000, 16'h0000, 16'h0008};
        vecs[2]  = '{"next3",   1'b0, NEXT,   16'h0000, 16'h0000, 16'h000C};
        vecs[3]  = '{"jmp_top", 1'b0, JUMP,   16'hFFFC, 16'h0000, 16'hFFFC};
        vecs[4]  = '{"wrap",    1'b0, NEXT,   16'h0000, 16'h0000, 16'h0000};
        vecs[5]  = '{"jmp10",   1'b0, JUMP,   16'h0010, 16'h0000, 16'h0010};
        vecs[6]  = '{"br_neg",  1'b0, BRANCH, 16'h0000, 16'hFFF0, 16'h0000};
        vecs[7]  = '{"br_pos",  1'b0, BRANCH, 16'h0000, 16'h0020, 16'h0020};
        vecs[8]  = '{"op5",     1'b0, 3'd5,   16'h1234, 16'h0100, 16'h0024};
        vecs[9]  = '{"op6",     1'b0, 3'd6,   16'h1234, 16'h0100, 16'h0028};
        vecs[10] = '{"op7",     1'b0, 3'd7,   16'h1234, 16'h0100, 16'h002C};
        vecs[11] = '{"stall1",  1'b1, JUMP,   16'h8000, 16'h0000, 16'h002C};
        vecs[12] = '{"stall2",  1'b1, JUMP,   16'h8000, 16'h0000, 16'h002C};
        vecs[13] = '{"stall3",  1'b1, JUMP,   16'h8000, 16'h0000, 16'h002C};
        vecs[14] = '{"jmp8000", 1'b0, JUMP,   16'h8000, 16'h0000, 16'h8000};

        step("rst0", 0, 0, NEXT, 16'h0, 16'h0, 0, 16'h0000, 1, 0, 0, 0);
        step("rst1", 0, 0, NEXT, 16'h0, 16'h0, 0, 16'h0000, 1, 0, 0, 0);
        foreach (vecs[i])
            step(vecs[i].name, 1, vecs[i].st, vecs[i].op, vecs[i].tgt, vecs[i].off, 0,
                 vecs[i].pc, 1, 0, 0, 0);

        step("a_jmp",   1, 0, JUMP, 16'h0100, 16'h0, 0, 16'h0100, 1, 0, 0, 0);
        step("a_call1", 1, 0, CALL, 16'h2000, 16'h0, 0, 16'h2000, NR, 0, 0, 0);
        step("a_call2", 1, 0, CALL, 16'h3000, 16'h0, 0, 16'h3000, NR, 0, 0, 0);
        step("a_ret1",  1, 0, RET,  16'h0, 16'h0, 0, RAS ? 16'h2004 : 16'h3004, NR, 0, 0, 0);
        step("a_ret2",  1, 0, RET,  16'h0, 16'h0, 0, RAS ? 16'h0104 : 16'h3008, 1, 0, 0, 0);

        step("b_jmp",   1, 0, JUMP, 16'h0000, 16'h0, 0, 16'h0000, 1, 0, 0, 0);
        step("b_call1", 1, 0, CALL, 16'h1000, 16'h0, 0, 16'h1000, NR, 0, 0, 0);
        step("b_call2", 1, 0, CALL, 16'h2000, 16'h0, 0, 16'h2000, NR, 0, 0, 0);
        step("b_call3", 1, 0, CALL, 16'h3000, 16'h0, 0, 16'h3000, NR, 0, 0, 0);
        step("b_call4", 1, 0, CALL, 16'h4000, 16'h0, 0, 16'h4000, NR, RAS, 0, 0);
        step("b_call5", 1, 0, CALL, 16'h5000, 16'h0, 0, 16'h5000, NR, RAS, RAS, 0);
        step("b_ret1",  1, 0, RET,  16'h0, 16'h0, 0, RAS ? 16'h4004 : 16'h5004, NR, 0, RAS, 0);
        step("b_ret2",  1, 0, RET,  16'h0, 16'h0, 0, RAS ? 16'h3004 : 16'h5008, NR, 0, RAS, 0);
        step("b_ret3",  1, 0, RET,  16'h0, 16'h0, 0, RAS ? 16'h2004 : 16'h500C, NR, 0, RAS, 0);
        step("b_ret4",  1, 0, RET,  16'h0, 16'h0, 0, RAS ? 16'h1004 : 16'h5010, 1, 0, RAS, 0);
        step("b_clr",   1, 0, NEXT, 16'h0, 16'h0, 1, RAS ? 16'h1008 : 16'h5014, 1, 0, 0, 0);

        step("c_jmp",     1, 0, JUMP, 16'h0040, 16'h0, 0, 16'h0040, 1, 0, 0, 0);
        step("c_ret",     1, 0, RET,  16'h0, 16'h0, 0, 16'h0044, 1, 0, 0, RAS);
        step("c_ret_clr", 1, 0, RET,  16'h0, 16'h0, 1, 16'h0048, 1, 0, 0, RAS);
        step("c_clr",     1, 0, NEXT, 16'h0, 16'h0, 1, 16'h004C, 1, 0, 0, 0);

        step("d_ret",       1, 0, RET,  16'h0, 16'h0, 0, 16'h0050, 1, 0, 0, RAS);
        step("d_call",      1, 0, CALL, 16'h2000, 16'h0, 0, 16'h2000, NR, 0, 0, RAS);
        step("d_stall_ret", 1, 1, RET,  16'h0, 16'h0, 0, 16'h2000, NR, 0, 0, RAS);
        step("d_rst",       0, 1, CALL, 16'h3000, 16'h0, 0, 16'h0000, 1, 0, 0, 0);
        step("d_ret_after", 1, 0, RET,  16'h0, 16'h0, 0, 16'h0004, 1, 0, 0, RAS);
        step("e_stall_clr", 1, 1, NEXT, 16'h0, 16'h0, 1, 16'h0004, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
